// File: rtl/cache_pkg.sv
// Shared defaults, derived widths and FSM state type for the cache data array.
package cache_pkg;

  // Default geometry.
  localparam int unsigned LINES_DEF      = 8;
  localparam int unsigned LINE_BYTES_DEF = 32;
  localparam int unsigned WORD_BYTES_DEF = 4;
  localparam int unsigned BEAT_BYTES_DEF = 8;

  // Widths derived for the default geometry.
  localparam int unsigned IDX_W  = $clog2(LINES_DEF);
  localparam int unsigned OFS_W  = $clog2(LINE_BYTES_DEF);
  localparam int unsigned WORD_W = 8 * WORD_BYTES_DEF;
  localparam int unsigned BEATS  = LINE_BYTES_DEF / BEAT_BYTES_DEF;
  localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [0:0] {
    StIdle,
    StFill
  } fill_state_t;

endpackage

// File: rtl/cache_line_reg.sv
// One cache line of byte-addressable storage with per-byte write enables.
module cache_line_reg
  import cache_pkg::*;
#(
  parameter int unsigned LINE_BYTES = LINE_BYTES_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [LINE_BYTES-1:0]   we,
  input  logic [8*LINE_BYTES-1:0] wdata,
  output logic [8*LINE_BYTES-1:0] rdata
);

  logic [8*LINE_BYTES-1:0] data_q;

  // Byte-granular storage; cleared asynchronously on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
    end else begin
      for (int i = 0; i < LINE_BYTES; i++) begin
        if (we[i]) data_q[i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  assign rdata = data_q;

endmodule

// File: rtl/cache_data_array.sv
// Multi-line cache data store: word reads, byte-masked writes and a
// multi-beat line refill engine with a valid/ready beat handshake.
module cache_data_array
  import cache_pkg::*;
#(
  parameter int unsigned LINES      = LINES_DEF,
  parameter int unsigned LINE_BYTES = LINE_BYTES_DEF,
  parameter int unsigned WORD_BYTES = WORD_BYTES_DEF,
  parameter int unsigned BEAT_BYTES = BEAT_BYTES_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_we,
  input  logic [$clog2(LINES)-1:0]      req_index,
  input  logic [$clog2(LINE_BYTES)-1:0] req_offset,
  input  logic [WORD_BYTES-1:0]         req_be,
  input  logic [8*WORD_BYTES-1:0]       req_wdata,
  output logic                          rsp_valid,
  output logic [8*WORD_BYTES-1:0]       rsp_rdata,
  input  logic                          fill_start,
  input  logic [$clog2(LINES)-1:0]      fill_index,
  input  logic                          fill_valid,
  output logic                          fill_ready,
  input  logic [8*BEAT_BYTES-1:0]       fill_data,
  output logic                          fill_done,
  output logic                          busy
);

  localparam int unsigned IdxW      = $clog2(LINES);
  localparam int unsigned LineW     = 8 * LINE_BYTES;
  localparam int unsigned WordW     = 8 * WORD_BYTES;
  localparam int unsigned Beats     = LINE_BYTES / BEAT_BYTES;
  localparam int unsigned Words     = LINE_BYTES / WORD_BYTES;
  localparam int unsigned CntW      = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int unsigned WordShift = $clog2(WORD_BYTES);

  fill_state_t     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0] fidx_q, fidx_d;

  logic req_acc, beat_acc, last_beat;
  int unsigned word_sel, beat_sel;

  logic [LINE_BYTES-1:0] req_mask, beat_mask;
  logic [LineW-1:0]      line_wdata;
  logic [LineW-1:0]      line_rdata [LINES];
  logic [LINE_BYTES-1:0] line_we    [LINES];
  logic [WordW-1:0]      old_word, merged_word;

  logic             rsp_valid_q, fill_done_q;
  logic [WordW-1:0] rsp_rdata_q;

  assign req_ready  = (state_q == StIdle) && !fill_start;
  assign fill_ready = (state_q == StFill);
  assign busy       = (state_q == StFill);

  assign req_acc   = req_valid && req_ready;
  assign beat_acc  = fill_ready && fill_valid;
  assign last_beat = (cnt_q == CntW'(Beats - 1));

  // FSM, beat counter and latched refill index registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      fidx_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fidx_q  <= fidx_d;
    end
  end

  // Next-state: fill_start wins over requests in IDLE; FILL ignores fill_start.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fidx_d  = fidx_q;
    unique case (state_q)
      StIdle: begin
        if (fill_start) begin
          state_d = StFill;
          cnt_d   = '0;
          fidx_d  = fill_index;
        end
      end
      StFill: begin
        if (fill_valid) begin
          cnt_d = cnt_q + CntW'(1);
          if (last_beat) begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Byte-enable masks within a line and the write data replicated across it.
  // Requests and beats are mutually exclusive by state, so one shared data bus suffices.
  always_comb begin
    word_sel  = 32'(req_offset) >> WordShift;
    beat_sel  = 32'(cnt_q);
    req_mask  = '0;
    beat_mask = '0;
    if (req_acc && req_we) req_mask[word_sel*WORD_BYTES +: WORD_BYTES] = req_be;
    if (beat_acc) beat_mask[beat_sel*BEAT_BYTES +: BEAT_BYTES] = '1;
    line_wdata = fill_ready ? {Beats{fill_data}} : {Words{req_wdata}};
  end

  for (genvar l = 0; l < LINES; l++) begin : g_line
    assign line_we[l] = ((req_index == IdxW'(l)) ? req_mask  : '0) |
                        ((fidx_q    == IdxW'(l)) ? beat_mask : '0);

    cache_line_reg #(
      .LINE_BYTES(LINE_BYTES)
    ) u_line (
      .clk  (clk),
      .reset(reset),
      .we   (line_we[l]),
      .wdata(line_wdata),
      .rdata(line_rdata[l])
    );
  end

  // Response word: stored word with enabled bytes replaced by write data.
  always_comb begin
    old_word = line_rdata[req_index][word_sel*WordW +: WordW];
    for (int k = 0; k < WORD_BYTES; k++) begin
      merged_word[k*8 +: 8] = (req_we && req_be[k]) ? req_wdata[k*8 +: 8] : old_word[k*8 +: 8];
    end
  end

  // Registered response and refill-complete pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      fill_done_q <= 1'b0;
    end else begin
      rsp_valid_q <= req_acc;
      if (req_acc) rsp_rdata_q <= merged_word;
      fill_done_q <= beat_acc && last_beat;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign fill_done = fill_done_q;

endmodule
